// File: rtl/hvac_sequencer.sv
// -----------------------------------------------------------------------------
// hvac_sequencer
//   Sequences the home heater and cooler from the temperature sensor ST.
//   Hysteresis thresholds keep the plant from chattering. A minimum run time
//   protects the compressor and burner. A changeover dead time separates
//   consecutive runs. The fire alarm (SFA) forces a lockout with both
//   actuators off.
//
// Optional feature: define HVAC_FAN_EN to add the fan output. The fan runs in
//   HEAT and COOL. It also runs in DWELL when DWELL follows a HEAT or COOL run
//   (post-run purge). It is off in IDLE and LOCK.
//
// Ports
//   Clk         in   1   system clock, rising edge
//   Rst         in   1   asynchronous active-low reset
//   en          in   1   HVAC enable; 0 = no new heat/cool cycle
//   SFA         in   1   fire alarm sensor, 1 = fire
//   ST          in   TW  current temperature (unsigned)
//   heater      out  1   heater drive  (decode of registered state)
//   cooler      out  1   cooler drive  (decode of registered state)
//   hvac_state  out  3   state code: IDLE=0 HEAT=1 COOL=2 DWELL=3 LOCK=4
//   fan         out  1   fan drive (only with HVAC_FAN_EN)
// -----------------------------------------------------------------------------
module hvac_sequencer #(
  parameter int TW       = 7,
  parameter int HEAT_ON  = 50,
  parameter int HEAT_OFF = 60,
  parameter int COOL_ON  = 80,
  parameter int COOL_OFF = 70,
  parameter int MIN_RUN  = 16,
  parameter int DEAD_CYC = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          en,
  input  logic          SFA,
  input  logic [TW-1:0] ST,
  output logic          heater,
  output logic          cooler,
`ifdef HVAC_FAN_EN
  output logic          fan,
`endif
  output logic [2:0]    hvac_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HEAT  = 3'd1;
  localparam logic [2:0] S_COOL  = 3'd2;
  localparam logic [2:0] S_DWELL = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;

  // The counter must hold the larger of the two reload values.
  localparam int CMAX = (MIN_RUN > DEAD_CYC) ? MIN_RUN : DEAD_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [TW-1:0] P_HEAT_ON  = TW'(HEAT_ON);
  localparam logic [TW-1:0] P_HEAT_OFF = TW'(HEAT_OFF);
  localparam logic [TW-1:0] P_COOL_ON  = TW'(COOL_ON);
  localparam logic [TW-1:0] P_COOL_OFF = TW'(COOL_OFF);
  localparam logic [CW-1:0] P_RUN_LD   = CW'(MIN_RUN - 1);
  localparam logic [CW-1:0] P_DEAD_LD  = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] P_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] P_ONE      = CW'(1);

  // Reject threshold orderings that would break the hysteresis bands.
  if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) && (COOL_OFF < COOL_ON) &&
        (COOL_ON <= (1 << TW) - 1))) begin : g_bad_thresholds
    $error("hvac_sequencer: threshold ordering violated");
  end
  if ((MIN_RUN < 1) || (DEAD_CYC < 1)) begin : g_bad_timing
    $error("hvac_sequencer: MIN_RUN and DEAD_CYC must be >= 1");
  end

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    w_next_state;
  logic [CW-1:0] w_next_cnt;

  // Next-state and counter logic; SFA overrides every other condition.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (SFA) begin
      w_next_state = S_LOCK;
      w_next_cnt   = P_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en && (ST < P_HEAT_ON)) begin
            w_next_state = S_HEAT;
            w_next_cnt   = P_RUN_LD;
          end else if (en && (ST > P_COOL_ON)) begin
            w_next_state = S_COOL;
            w_next_cnt   = P_RUN_LD;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_HEAT: begin
          // The exit test is evaluated only once the minimum run has elapsed.
          if (r_cnt != P_ZERO) begin
            w_next_cnt = r_cnt - P_ONE;
          end else if ((ST >= P_HEAT_OFF) || !en) begin
            w_next_state = S_DWELL;
            w_next_cnt   = P_DEAD_LD;
          end else begin
            w_next_state = S_HEAT;
          end
        end
        S_COOL: begin
          if (r_cnt != P_ZERO) begin
            w_next_cnt = r_cnt - P_ONE;
          end else if ((ST <= P_COOL_OFF) || !en) begin
            w_next_state = S_DWELL;
            w_next_cnt   = P_DEAD_LD;
          end else begin
            w_next_state = S_COOL;
          end
        end
        S_DWELL: begin
          if (r_cnt != P_ZERO) begin
            w_next_cnt = r_cnt - P_ONE;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_LOCK: begin
          // The alarm has cleared. Restart only after a full dead time.
          w_next_state = S_DWELL;
          w_next_cnt   = P_DEAD_LD;
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_cnt   = P_ZERO;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= P_ZERO;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Outputs decode the registered state, so reset drops them immediately.
  assign heater     = (r_state == S_HEAT);
  assign cooler     = (r_state == S_COOL);
  assign hvac_state = r_state;

`ifdef HVAC_FAN_EN
  logic r_purge;

  // Record on DWELL entry whether it follows a run (purge) or a lockout.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_purge <= 1'b0;
    end else if ((w_next_state == S_DWELL) && (r_state != S_DWELL)) begin
      r_purge <= (r_state == S_HEAT) || (r_state == S_COOL);
    end else begin
      r_purge <= r_purge;
    end
  end

  assign fan = (r_state == S_HEAT) || (r_state == S_COOL) ||
               ((r_state == S_DWELL) && r_purge);
`endif

endmodule

// File: tb/tb_hvac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hvac_sequencer
//   Directed bench for hvac_sequencer. A mode/age model (cycles spent in the
//   current mode) predicts the outputs and is compared on every falling edge.
//   Hand-computed literal expectations along the directed scenarios pin the
//   model itself.
// -----------------------------------------------------------------------------
module tb_hvac_sequencer;

  localparam int MIN_RUN  = 16;
  localparam int DEAD_CYC = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       en;
  logic       SFA;
  logic [6:0] ST;
  logic       heater;
  logic       cooler;
  logic [2:0] hvac_state;
`ifdef HVAC_FAN_EN
  logic       fan;
`endif

  int n_checks = 0;
  int n_err    = 0;

  hvac_sequencer dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .en         (en),
    .SFA        (SFA),
    .ST         (ST),
    .heater     (heater),
    .cooler     (cooler),
`ifdef HVAC_FAN_EN
    .fan        (fan),
`endif
    .hvac_state (hvac_state)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes: 0 idle, 1 heat, 2 cool, 3 dwell, 4 lock. m_age counts completed
  // cycles in the current mode (0 on the first cycle of a mode).
  int m_mode;
  int m_age;
  bit m_purge;

  function automatic int next_mode(input int mode, input int age);
    if (SFA) return 4;
    case (mode)
      0: begin
        if (en && ST < 7'd50) return 1;
        if (en && ST > 7'd80) return 2;
        return 0;
      end
      1: return (age >= MIN_RUN - 1 && (ST >= 7'd60 || !en)) ? 3 : 1;
      2: return (age >= MIN_RUN - 1 && (ST <= 7'd70 || !en)) ? 3 : 2;
      3: return (age >= DEAD_CYC - 1) ? 0 : 3;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_mode  <= 0;
      m_age   <= 0;
      m_purge <= 1'b0;
    end else begin
      m_mode <= next_mode(m_mode, m_age);
      m_age  <= (next_mode(m_mode, m_age) == m_mode) ? m_age + 1 : 0;
      if (next_mode(m_mode, m_age) == 3 && m_mode != 3)
        m_purge <= (m_mode == 1 || m_mode == 2);
    end
  end

  bit run_checks = 1'b0;

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (run_checks) begin
      chk("model_state",  int'(hvac_state), m_mode);
      chk("model_heater", int'(heater), int'(m_mode == 1));
      chk("model_cooler", int'(cooler), int'(m_mode == 2));
      chk("mutex",        int'(heater & cooler), 0);
`ifdef HVAC_FAN_EN
      chk("model_fan", int'(fan),
          int'(m_mode == 1 || m_mode == 2 || (m_mode == 3 && m_purge)));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b1; en = 1'b0; SFA = 1'b0; ST = 7'd65;
    #1 Rst = 1'b0;
    run_checks = 1'b1;
    cyc(2);
    chk("reset_state",  int'(hvac_state), 0);
    chk("reset_heater", int'(heater), 0);
    chk("reset_cooler", int'(cooler), 0);
    Rst = 1'b1;

    // 1: asynchronous reset mid-HEAT, then re-entry one edge after release
    en = 1'b1; ST = 7'd45;
    cyc(5);
    chk("t1_heating", int'(heater), 1);
    @(posedge Clk); #2 Rst = 1'b0; #1;
    chk("t1_async_heater", int'(heater), 0);
    chk("t1_async_state",  int'(hvac_state), 0);
    @(negedge Clk); Rst = 1'b1;
    cyc(1);
    chk("t1_reentry", int'(hvac_state), 1);
    // en drops mid-run: the run still completes, then DWELL and IDLE
    en = 1'b0;
    cyc(15);
    chk("t1_en_low_minrun", int'(heater), 1);
    cyc(10);
    chk("t1_back_idle", int'(hvac_state), 0);

    // 2: heat run with ST=62 from run cycle 3 -> 16 heat, 4 dwell, idle
    en = 1'b1; ST = 7'd45;
    for (int i = 1; i <= 21; i++) begin
      @(negedge Clk);
      chk("t2_state", int'(hvac_state), (i <= 16) ? 1 : ((i <= 20) ? 3 : 0));
`ifdef HVAC_FAN_EN
      chk("t2_fan", int'(fan), int'(i <= 20));
`endif
      if (i == 2) ST = 7'd62;
    end

    // 3: hysteresis band keeps heating; ST=60 exits on the next edge
    ST = 7'd45;
    cyc(1);
    chk("t3_enter", int'(hvac_state), 1);
    ST = 7'd55;
    cyc(35);
    chk("t3_band", int'(heater), 1);
    ST = 7'd60;
    cyc(1);
    chk("t3_exit", int'(hvac_state), 3);
    cyc(4);
    chk("t3_idle", int'(hvac_state), 0);

    // 4: heat -> dwell -> idle -> cool on changeover
    ST = 7'd45;
    cyc(16);
    chk("t4_heat_c16", int'(heater), 1);
    ST = 7'd90;
    cyc(1);
    chk("t4_dwell", int'(hvac_state), 3);
    chk("t4_dwell_heater", int'(heater), 0);
    cyc(4);
    chk("t4_idle", int'(hvac_state), 0);
    cyc(1);
    chk("t4_cool", int'(cooler), 1);

    // 5: SFA in COOL cycle 2 -> lock, release -> dwell 4 -> idle -> cool
    cyc(1);
    SFA = 1'b1;
    cyc(1);
    chk("t5_lock", int'(hvac_state), 4);
    chk("t5_lock_cooler", int'(cooler), 0);
    cyc(9);
    SFA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("t5_dwell", int'(hvac_state), 3);
`ifdef HVAC_FAN_EN
      chk("t5_fan_off", int'(fan), 0);
`endif
    end
    cyc(1);
    chk("t5_idle", int'(hvac_state), 0);
    cyc(1);
    chk("t5_cool_again", int'(hvac_state), 2);

    // Boundaries: thresholds are strict on entry
    ST = 7'd70;
    cyc(25);
    chk("b_cool_done", int'(hvac_state), 0);
    ST = 7'd50;
    cyc(3);
    chk("b_heat_on_edge", int'(hvac_state), 0);
    ST = 7'd80;
    cyc(3);
    chk("b_cool_on_edge", int'(hvac_state), 0);
    ST = 7'd49;
    cyc(1);
    chk("b_heat_49", int'(hvac_state), 1);
    // SFA overrides the minimum run
    SFA = 1'b1;
    cyc(1);
    chk("b_sfa_override", int'(hvac_state), 4);
    SFA = 1'b0;
    cyc(5);
    chk("b_after_lock_idle", int'(hvac_state), 0);
    cyc(1);
    chk("b_reheat", int'(hvac_state), 1);

    run_checks = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
